// File: rtl/traffic_pkg.sv
// traffic_pkg: shared state encoding, light patterns and night digit code for the sequencer and display driver
package traffic_pkg;
  typedef enum logic [2:0] {
    CLR_A  = 3'd0,
    MAIN_G = 3'd1,
    MAIN_Y = 3'd2,
    CLR_B  = 3'd3,
    SIDE_G = 3'd4,
    SIDE_Y = 3'd5,
    NIGHT  = 3'd6
  } state_e;
  localparam logic [5:0] L_CLR    = 6'b100100;
  localparam logic [5:0] L_MAIN_G = 6'b001100;
  localparam logic [5:0] L_MAIN_Y = 6'b010100;
  localparam logic [5:0] L_SIDE_G = 6'b100001;
  localparam logic [5:0] L_SIDE_Y = 6'b100010;
  localparam logic [5:0] L_NIGHT  = 6'b010010;
  localparam logic [5:0] L_OFF    = 6'b000000;
  localparam logic [3:0] NIGHT_DIGIT = 4'hD;
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic logic [5:0] light_of(input state_e s);
    return (s == MAIN_G) ? L_MAIN_G : (s == MAIN_Y) ? L_MAIN_Y :
           (s == SIDE_G) ? L_SIDE_G : (s == SIDE_Y) ? L_SIDE_Y : L_CLR;
  endfunction
  function automatic state_e next_of(input state_e s);
    return (s == SIDE_Y) ? CLR_A : state_e'(s + 3'd1);
  endfunction
endpackage

// File: rtl/traffic_bcd_cnt.sv
// traffic_bcd_cnt: loadable two-digit BCD down-counter with enable and count==1 flag
module traffic_bcd_cnt (
  input  logic       clk_i,
  input  logic       load_i,
  input  logic [7:0] val_i,
  input  logic       en_i,
  output logic [3:0] tens_o,
  output logic [3:0] ones_o,
  output logic       one_o
);
  logic [7:0] cnt_q;
  always_ff @(posedge clk_i)
    if (load_i) cnt_q <= val_i;
    else if (en_i) cnt_q <= (cnt_q[3:0] == 4'd0) ? {cnt_q[7:4] - 4'd1, 4'd9} : {cnt_q[7:4], cnt_q[3:0] - 4'd1};
  assign tens_o = cnt_q[7:4];
  assign ones_o = cnt_q[3:0];
  assign one_o  = cnt_q == 8'h01;
endmodule

// File: rtl/traffic_seq.sv
// traffic_seq: two-road traffic light sequencer with BCD countdown and night flashing mode.
// Define TRAFFIC_SEQ_REQ_EN to enable request latches that truncate the opposing green.
module traffic_seq
  import traffic_pkg::*;
#(
  parameter int CLK_DIV  = 1000,
  parameter int T_MAIN_G = 29,
  parameter int T_SIDE_G = 19,
  parameter int T_YEL    = 3,
  parameter int T_CLR    = 2,
  parameter int T_PED    = 5
) (
  input  logic       clk1khz,
  input  logic       rst,
  input  logic       night,
  input  logic       req_main,
  input  logic       req_side,
  output logic [5:0] light,
  output logic [3:0] cnt_tens,
  output logic [3:0] cnt_ones,
  output logic [2:0] phase,
  output logic       tick
);
  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);
  logic [15:0] pre_q;
  logic        tick_q, flash_q, flash_d, side_q, main_q;
  state_e      state_q, state_d, nxt;
  logic [5:0]  light_q, light_d;
  logic [3:0]  tens, ones;
  logic [6:0]  cnt_bin;
  logic [7:0]  load_val;
  logic        one, load, en, trunc;
  function automatic logic [7:0] dur(input state_e s);
    return (s == MAIN_G) ? to_bcd(T_MAIN_G) : (s == SIDE_G) ? to_bcd(T_SIDE_G) :
           (s == MAIN_Y || s == SIDE_Y) ? to_bcd(T_YEL) : to_bcd(T_CLR);
  endfunction
  traffic_bcd_cnt u_cnt (
    .clk_i (clk1khz),
    .load_i(load),
    .val_i (load_val),
    .en_i  (en),
    .tens_o(tens),
    .ones_o(ones),
    .one_o (one)
  );
  assign cnt_bin = 7'({3'b0, tens} * 7'd10 + {3'b0, ones});
  assign trunc   = ((state_q == MAIN_G && side_q) || (state_q == SIDE_G && main_q)) && cnt_bin > 7'(T_PED);
  assign nxt     = next_of(state_q);
  always_comb begin
    state_d  = state_q;
    light_d  = light_q;
    flash_d  = flash_q;
    load     = rst;
    load_val = to_bcd(T_CLR);
    en       = 1'b0;
    if (!rst && tick_q) begin
      if (night) begin
        state_d  = NIGHT;
        flash_d  = (state_q == NIGHT) ? ~flash_q : 1'b1;
        light_d  = (state_q == NIGHT && flash_q) ? L_OFF : L_NIGHT;
        load     = 1'b1;
        load_val = {NIGHT_DIGIT, NIGHT_DIGIT};
      end else if (state_q == NIGHT) begin
        state_d = CLR_A;
        light_d = L_CLR;
        flash_d = 1'b0;
        load    = 1'b1;
      end else if (one) begin
        state_d  = nxt;
        light_d  = light_of(nxt);
        load     = 1'b1;
        load_val = dur(nxt);
      end else if (trunc) begin
        load     = 1'b1;
        load_val = to_bcd(T_PED);
      end else en = 1'b1;
    end
  end
  always_ff @(posedge clk1khz)
    if (rst) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      state_q <= CLR_A;
      light_q <= L_CLR;
      flash_q <= 1'b0;
    end else begin
      pre_q   <= (pre_q == DIV_LAST) ? '0 : pre_q + 16'd1;
      tick_q  <= pre_q == DIV_LAST;
      state_q <= state_d;
      light_q <= light_d;
      flash_q <= flash_d;
    end
`ifdef TRAFFIC_SEQ_REQ_EN
  logic night_clr, set_side, set_main;
  // a request arriving on the entry cycle survives the clear; night entry wins
  assign night_clr = tick_q & night;
  assign set_side  = req_side & (state_q != NIGHT) & ~night_clr;
  assign set_main  = req_main & (state_q != NIGHT) & ~night_clr;
  always_ff @(posedge clk1khz)
    if (rst) begin
      side_q <= 1'b0;
      main_q <= 1'b0;
    end else begin
      side_q <= set_side | (side_q & ~night_clr & ~(state_d == SIDE_G && state_q != SIDE_G));
      main_q <= set_main | (main_q & ~night_clr & ~(state_d == MAIN_G && state_q != MAIN_G));
    end
`else
  logic unused_req;
  assign unused_req = req_main ^ req_side;
  assign side_q = 1'b0;
  assign main_q = 1'b0;
`endif
  assign light    = light_q;
  assign cnt_tens = tens;
  assign cnt_ones = ones;
  assign phase    = state_q;
  assign tick     = tick_q;
endmodule

// File: tb/tb_traffic_seq.sv
// tb_traffic_seq: directed scenarios plus randomized requests/night/reset against a tick-level integer model
module tb_traffic_seq;
  localparam int DIV = 4, TMG = 29, TSG = 19, TY = 3, TC = 2, TP = 5;
  logic clk1khz = 1'b0, rst = 1'b1, night = 1'b0, req_main = 1'b0, req_side = 1'b0;
  logic [5:0] light;
  logic [3:0] cnt_tens, cnt_ones;
  logic [2:0] phase;
  logic       tick;
  int vectors = 0, errors = 0;
  bit chk_en = 1'b0;
  traffic_seq #(.CLK_DIV(DIV), .T_MAIN_G(TMG), .T_SIDE_G(TSG), .T_YEL(TY), .T_CLR(TC), .T_PED(TP)) dut (
    .clk1khz(clk1khz), .rst(rst), .night(night), .req_main(req_main), .req_side(req_side),
    .light(light), .cnt_tens(cnt_tens), .cnt_ones(cnt_ones), .phase(phase), .tick(tick)
  );
  always #5 clk1khz = ~clk1khz;
  int m_pre = 0, m_ph = 0, m_rem = TC;
  bit m_tick = 1'b0, m_side = 1'b0, m_main = 1'b0, m_fl = 1'b0;
  int dur[6] = '{TC, TMG, TY, TC, TSG, TY};
  logic [5:0] lt[6] = '{6'b100100, 6'b001100, 6'b010100, 6'b100100, 6'b100001, 6'b100010};
  always @(posedge clk1khz) begin : model
    int oph;
    bit ot;
    if (rst) begin
      m_pre = 0; m_tick = 0; m_ph = 0; m_rem = TC; m_side = 0; m_main = 0; m_fl = 0;
    end else begin
      oph = m_ph;
      ot = m_tick;
      m_tick = (m_pre == DIV - 1);
      m_pre = (m_pre + 1) % DIV;
      if (ot) begin
        if (night) begin
          m_fl = (m_ph == 6) ? !m_fl : 1'b1;
          m_ph = 6;
        end else if (m_ph == 6) begin
          m_ph = 0; m_rem = TC;
        end else if (m_rem == 1) begin
          m_ph = (m_ph + 1) % 6; m_rem = dur[m_ph];
        end else if (((m_ph == 1 && m_side) || (m_ph == 4 && m_main)) && m_rem > TP) m_rem = TP;
        else m_rem = m_rem - 1;
      end
`ifdef TRAFFIC_SEQ_REQ_EN
      if (ot && night) begin m_side = 0; m_main = 0; end
      if (m_ph == 4 && oph != 4) m_side = 0;
      if (m_ph == 1 && oph != 1) m_main = 0;
      if (oph != 6 && !(ot && night)) begin
        if (req_side) m_side = 1;
        if (req_main) m_main = 1;
      end
`endif
    end
  end
  function automatic logic [17:0] m_out();
    logic [5:0] l;
    logic [7:0] d;
    l = (m_ph == 6) ? (m_fl ? 6'b010010 : 6'b000000) : lt[m_ph];
    d = (m_ph == 6) ? 8'hDD : {4'(m_rem / 10), 4'(m_rem % 10)};
    return {m_tick, 3'(m_ph), l, d};
  endfunction
  always @(negedge clk1khz)
    if (chk_en) begin
      vectors++;
      if ({tick, phase, light, cnt_tens, cnt_ones} !== m_out()) begin
        errors++;
        $display("FAIL cycle t=%0t {tick,phase,light,digits} got %h expected %h", $time,
                 {tick, phase, light, cnt_tens, cnt_ones}, m_out());
      end
    end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  task automatic wait_model(input int ph, input int rem, input int lim, input string nm);
    int i;
    i = 0;
    while (!(m_ph == ph && (rem < 0 || m_rem == rem)) && i < lim) begin
      @(negedge clk1khz);
      i++;
    end
    if (!(m_ph == ph && (rem < 0 || m_rem == rem))) chk({nm, "_timeout"}, 32'(i), 32'(lim + 1));
  endtask
  task automatic wait_dut(input logic [2:0] p, input int lim, output int nt, input string nm);
    int i;
    i = 0;
    nt = 0;
    while (phase !== p && i < lim) begin
      if (tick === 1'b1) nt++;
      @(negedge clk1khz);
      i++;
    end
    if (phase !== p) chk({nm, "_timeout"}, 32'(phase), 32'(p));
  endtask
  initial begin
    int n1, n2, night_left;
    repeat (2) @(negedge clk1khz);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_light", 32'(light), 32'b100100);
    chk("rst_digits", 32'({cnt_tens, cnt_ones}), 32'h02);
    chk("rst_tick", 32'(tick), 0);
    rst = 1'b0;
    chk_en = 1'b1;
    wait_dut(3'd1, 100, n1, "first_main");
    chk("clr_a_ticks", 32'(n1), 2);
    chk("main_g_light", 32'(light), 32'b001100);
    chk("main_g_load", 32'({cnt_tens, cnt_ones}), 32'h29);
    wait_dut(3'd2, 400, n1, "leave_main");
    wait_dut(3'd1, 400, n2, "back_main");
    chk("main_g_ticks", 32'(n1), 29);
    chk("cycle_ticks", 32'(n1 + n2), 58);
    wait_model(1, 20, 200, "main20");
    req_side = 1'b1;
    @(negedge clk1khz);
    req_side = 1'b0;
`ifdef TRAFFIC_SEQ_REQ_EN
    wait_model(1, 5, 20, "trunc");
    chk("trunc_digits", 32'({cnt_tens, cnt_ones}), 32'h05);
`else
    wait_model(1, 19, 20, "no_trunc");
    chk("full_green_digits", 32'({cnt_tens, cnt_ones}), 32'h19);
`endif
    wait_dut(3'd2, 200, n1, "main_y");
    chk("main_y_light", 32'(light), 32'b010100);
    chk("main_y_digits", 32'({cnt_tens, cnt_ones}), 32'h03);
    wait_model(4, 3, 400, "side3");
    req_main = 1'b1;
    @(negedge clk1khz);
    req_main = 1'b0;
    wait_model(4, 2, 20, "side2");
    chk("late_req_no_reload", 32'({cnt_tens, cnt_ones}), 32'h02);
    wait_model(4, 10, 600, "side10");
    night = 1'b1;
    wait_model(6, -1, 20, "night_entry");
    chk("night_phase", 32'(phase), 6);
    chk("night_light_on", 32'(light), 32'b010010);
    chk("night_digits", 32'({cnt_tens, cnt_ones}), 32'hDD);
    repeat (DIV) @(negedge clk1khz);
    chk("night_light_off", 32'(light), 32'b000000);
    repeat (DIV) @(negedge clk1khz);
    chk("night_light_on2", 32'(light), 32'b010010);
    night = 1'b0;
    wait_model(0, -1, 20, "night_exit");
    chk("night_exit_digits", 32'({cnt_tens, cnt_ones}), 32'h02);
    chk("night_exit_light", 32'(light), 32'b100100);
    wait_model(1, 15, 300, "main15");
    rst = 1'b1;
    @(negedge clk1khz);
    rst = 1'b0;
    chk("midrst_phase", 32'(phase), 0);
    chk("midrst_digits", 32'({cnt_tens, cnt_ones}), 32'h02);
    chk("midrst_light", 32'(light), 32'b100100);
    night_left = 0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk1khz);
      req_main = ($urandom_range(0, 39) == 0);
      req_side = ($urandom_range(0, 39) == 0);
      rst = ($urandom_range(0, 2999) == 0);
      if (night_left > 0) night_left--;
      else if ($urandom_range(0, 699) == 0) night_left = $urandom_range(10, 60);
      night = night_left > 0;
    end
    @(negedge clk1khz);
    req_main = 1'b0;
    req_side = 1'b0;
    rst = 1'b0;
    night = 1'b0;
    @(negedge clk1khz);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/traffic_seq.md
TRAFFIC_SEQ -- requirements
Module: traffic_seq

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk1khz cycles per one-second tick (legal range 2..65535).
REQ-002 Parameter T_MAIN_G, default 29, main green duration in ticks (1..99).
REQ-003 Parameter T_SIDE_G, default 19, side green duration in ticks (1..99).
REQ-004 Parameter T_YEL, default 3, yellow duration in ticks (1..99).
REQ-005 Parameter T_CLR, default 2, all-red clearance duration in ticks (1..99).
REQ-006 Parameter T_PED, default 5, truncated remaining green after a request (1..99).
REQ-007 clk1khz  in  1  sole clock; all state changes on its rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 night  in  1  level; 1 selects flashing-yellow night mode.
REQ-010 req_main  in  1  single-cycle pulse; request to serve main road.
REQ-011 req_side  in  1  single-cycle pulse; request to serve side road.
REQ-012 light  out  6  {main R,Y,G, side R,Y,G}, one-hot per road.
REQ-013 cnt_tens  out  4  BCD tens digit of remaining ticks; 4'hD in night mode.
REQ-014 cnt_ones  out  4  BCD ones digit of remaining ticks; 4'hD in night mode.
REQ-015 phase  out  3  current state encoding.
REQ-016 tick  out  1  one-cycle strobe, 1 on the cycle the prescaler wraps.

Function
REQ-017 Prescaler counts 0..CLK_DIV-1, wraps to 0 and asserts tick for that one cycle.
REQ-018 States: CLR_A(0), MAIN_G(1), MAIN_Y(2), CLR_B(3), SIDE_G(4), SIDE_Y(5), NIGHT(6); sequence CLR_A->MAIN_G->MAIN_Y->CLR_B->SIDE_G->SIDE_Y->CLR_A.
REQ-019 On state entry the BCD counter loads that state's duration (CLR_*: T_CLR, *_G: T_*_G, *_Y: T_YEL).
REQ-020 On each tick with count > 1, count decrements by 1 in BCD (ones 0 borrows: ones=9, tens-1); on tick with count == 1 the state advances and the next duration loads, so each state lasts exactly its duration in ticks, displayed D..1.
REQ-021 light: CLR_* 100100; MAIN_G 001100; MAIN_Y 010100; SIDE_G 100001; SIDE_Y 100010.
REQ-022 req_side pulse sets a side latch; req_main sets a main latch; pulses outside green states still latch.
REQ-023 In MAIN_G with side latch set, the next tick loads T_PED instead of decrementing if count > T_PED; otherwise normal decrement; same for SIDE_G with main latch.
REQ-024 Side latch clears on entry to SIDE_G, main latch on entry to MAIN_G; a set and clear in the same cycle leaves the latch set.
REQ-025 night=1 sampled on a tick forces NIGHT from any state on that tick; in NIGHT light alternates 010010 / 000000 each tick starting with 010010, and digits show 4'hD.
REQ-026 night=0 on a tick while in NIGHT moves to CLR_A with T_CLR loaded; both latches clear on NIGHT entry.
REQ-027 Requests in NIGHT are ignored; night has priority over truncation on the same tick.
REQ-028 All outputs registered; state/light/digits change one cycle after the tick cycle.

Reset
REQ-029 rst=1 on an edge: prescaler 0, tick 0, state CLR_A, count BCD 02 (T_CLR), light 100100, latches 0, flash phase 0; rst wins over every simultaneous event, including mid-countdown and in NIGHT.

Configuration
REQ-030 Macro TRAFFIC_SEQ_REQ_EN defined: REQ-022..024 active; undefined: req_main/req_side ports remain but are ignored, no latches synthesized, greens always run full duration.

Structure
REQ-031 Shared package traffic_pkg holds the state encoding, light pattern constants and the 4'hD night-digit code, for reuse by the display/scan driver.
REQ-032 One sub-module traffic_bcd_cnt: loadable two-digit BCD down-counter with enable, returning count==1 flag.

Verification
REQ-033 CLK_DIV=4, rst released -> CLR_A for 2 ticks (02,01), then MAIN_G loads 29, light 001100.
REQ-034 Full cycle defaults -> MAIN_G 29, MAIN_Y 3, CLR_B 2, SIDE_G 19, SIDE_Y 3, CLR_A 2 ticks; total 58 ticks, back to MAIN_G.
REQ-035 req_side pulse with MAIN_G count 20 -> next tick shows 05, then 04..01, MAIN_Y; request at count 03 -> no reload.
REQ-036 night=1 mid SIDE_G -> NIGHT on tick, digits DD, light 010010/000000 alternating; night=0 -> CLR_A showing 02.
REQ-037 rst pulse at MAIN_G count 15 -> next cycle CLR_A, 02, light 100100, latches cleared.
REQ-038 Macro undefined, req_side pulses during MAIN_G -> green runs full 29 ticks.
